// File: rtl/q_meas_scheduler.sv
// Round-robin scheduler sharing one charge-measurement unit between N_CH pulse channels.
// Optional build macro QSCHED_SKIP_ZERO_EN drops zero-charge (non-timeout) results.
module q_meas_scheduler #(
  parameter int N_CH       = 4,
  parameter int BUS_WIDTH  = 10,
  parameter int CH_W       = 2,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      ch_mask,
  input  logic [N_CH-1:0]      q_serialized_in,
  output logic                 meas_q_serialized,
  output logic                 meas_start,
  input  logic                 meas_ready,
  input  logic [BUS_WIDTH-1:0] meas_q,
  output logic                 result_valid,
  output logic [CH_W-1:0]      result_ch,
  output logic [BUS_WIDTH-1:0] result_q,
  output logic                 result_timeout,
  input  logic                 result_ack
);

  // state   | meaning
  // IDLE    | waiting for enable and a non-empty channel mask
  // SELECT  | advance cur_ch to the next enabled channel (one cycle)
  // SETTLE  | meas_start held low for SETTLE_CYC cycles
  // MEASURE | meas_start high, pulse line routed, wait for ready or timeout
  // HOLD    | result presented, waiting for result_ack
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  // Counter value in the last MEASURE cycle; the timeout edge takes it to 2**TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        cur_ch_q, cur_ch_d;
  logic [3:0]             settle_q, settle_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [CH_W-1:0]        res_ch_q, res_ch_d;
  logic [BUS_WIDTH-1:0]   res_val_q, res_val_d;
  logic                   res_to_q, res_to_d;

  logic [CH_W-1:0]        nxt_ch;
  logic [CH_W-1:0]        first_any;
  logic [CH_W-1:0]        first_above;
  logic                   has_above;
  logic                   drop_zero;

`ifdef QSCHED_SKIP_ZERO_EN
  assign drop_zero = (meas_q == '0);
`else
  assign drop_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_ch_q  <= CH_W'(N_CH - 1);
      settle_q  <= '0;
      tmo_q     <= '0;
      res_ch_q  <= '0;
      res_val_q <= '0;
      res_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      res_ch_q  <= res_ch_d;
      res_val_q <= res_val_d;
      res_to_q  <= res_to_d;
    end
  end

  // Descending scan so the last hit is the lowest matching index.
  always_comb begin
    first_any   = '0;
    first_above = '0;
    has_above   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_any = CH_W'(i);
        if (i > int'(cur_ch_q)) begin
          first_above = CH_W'(i);
          has_above   = 1'b1;
        end
      end
    end
    nxt_ch = has_above ? first_above : first_any;
  end

  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    settle_d  = settle_q;
    tmo_d     = '0;
    res_ch_d  = res_ch_q;
    res_val_d = res_val_q;
    res_to_d  = res_to_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (ch_mask != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (ch_mask != '0) begin
          cur_ch_d = nxt_ch;
          settle_d = SETTLE_LD;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_MEASURE;
        else settle_d = settle_q - 4'd1;
      end
      S_MEASURE: begin
        tmo_d = tmo_q + 1'b1;
        if (meas_ready) begin
          if (drop_zero) begin
            state_d = enable ? S_SELECT : S_IDLE;
          end else begin
            res_ch_d  = cur_ch_q;
            res_val_d = meas_q;
            res_to_d  = 1'b0;
            state_d   = S_HOLD;
          end
        end else if (tmo_q == TMO_LAST) begin
          res_ch_d  = cur_ch_q;
          res_val_d = '0;
          res_to_d  = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (result_ack) state_d = enable ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meas_start        = (state_q == S_MEASURE);
    result_valid      = (state_q == S_HOLD);
    meas_q_serialized = (state_q == S_MEASURE) ? q_serialized_in[cur_ch_q] : 1'b0;
    result_ch         = res_ch_q;
    result_q          = res_val_q;
    result_timeout    = res_to_q;
  end

endmodule

// File: tb/tb_q_meas_scheduler.sv
// Self-checking bench for q_meas_scheduler: directed scenarios plus a randomized
// round-robin run checked against a modulo-arithmetic channel model.
module tb_q_meas_scheduler;
  localparam int N_CH   = 4;
  localparam int BW     = 10;
  localparam int CH_W   = 2;
  localparam int SETTLE = 2;
  localparam int TW     = 8;
  localparam int TMO_CYC = (2 ** TW) - 1;

  logic            clk, rst, enable, meas_q_serialized, meas_start, meas_ready;
  logic [N_CH-1:0] ch_mask, q_serialized_in;
  logic [BW-1:0]   meas_q, result_q;
  logic            result_valid, result_timeout, result_ack;
  logic [CH_W-1:0] result_ch;

  int n_run = 0;
  int n_fail = 0;

  q_meas_scheduler #(
    .N_CH(N_CH), .BUS_WIDTH(BW), .CH_W(CH_W), .SETTLE_CYC(SETTLE), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .q_serialized_in(q_serialized_in), .meas_q_serialized(meas_q_serialized),
    .meas_start(meas_start), .meas_ready(meas_ready), .meas_q(meas_q),
    .result_valid(result_valid), .result_ch(result_ch), .result_q(result_q),
    .result_timeout(result_timeout), .result_ack(result_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; ch_mask = '0; meas_ready = 1'b0; meas_q = '0;
    result_ack = 1'b0; q_serialized_in = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // Next enabled channel after cur in cyclic order.
  function automatic int ref_next(int cur, logic [N_CH-1:0] m);
    int c;
    for (int k = 1; k <= N_CH; k++) begin
      c = (cur + k) % N_CH;
      if (m[c]) return c;
    end
    return cur;
  endfunction

  task automatic start_scan(input logic [N_CH-1:0] m);
    ch_mask = m;
    enable  = 1'b1;
    step();
  endtask

  // Plays the measurement unit: ready in MEASURE cycle ready_at (-1 = never).
  task automatic do_meas(input int ready_at, input logic [BW-1:0] qv, input int drop_at,
                         output int pre, output int mc, output logic got);
    pre = 0;
    while (meas_start !== 1'b1 && pre < 50) begin
      step();
      pre++;
    end
    mc = 0;
    while (meas_start === 1'b1 && result_valid !== 1'b1 && mc < 400) begin
      if (mc == drop_at) enable = 1'b0;
      if (mc == ready_at) begin
        meas_ready = 1'b1; meas_q = qv;
      end else begin
        meas_ready = 1'b0; meas_q = BW'($urandom);
      end
      mc++;
      step();
    end
    meas_ready = 1'b0;
    got = (result_valid === 1'b1);
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    q_serialized_in = '1; meas_ready = 1'b1; meas_q = 10'd77; result_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_run++;
      if ({meas_start, result_valid, result_ch, result_q, result_timeout, meas_q_serialized} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got start=%b valid=%b ch=%0d q=%0d to=%b mux=%b exp all 0",
                 i, meas_start, result_valid, result_ch, result_q, result_timeout, meas_q_serialized);
      end
    end
    meas_ready = 1'b0; result_ack = 1'b0;
  endtask

  task automatic test_basic();
    int pre, mc, exp_cur, exp_ch;
    logic got;
    logic [BW-1:0] qv;
    apply_reset();
    start_scan(4'b0101);
    exp_cur = N_CH - 1;
    for (int i = 0; i < 3; i++) begin
      exp_ch = ref_next(exp_cur, 4'b0101);
      exp_cur = exp_ch;
      qv = (exp_ch == 0) ? 10'd150 : 10'd90;
      do_meas(3, qv, -1, pre, mc, got);
      n_run++;
      if (pre != 1 + SETTLE) begin
        n_fail++; $display("FAIL basic_settle got=%0d exp=%0d", pre, 1 + SETTLE);
      end
      n_run++;
      if (!got || result_ch !== CH_W'(exp_ch) || result_q !== qv || result_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_result got v=%b ch=%0d q=%0d to=%b exp ch=%0d q=%0d to=0",
                 got, result_ch, result_q, result_timeout, exp_ch, qv);
      end
      n_run++;
      if (mc != 4) begin
        n_fail++; $display("FAIL basic_latency got=%0d exp=4", mc);
      end
      do_ack();
      n_run++;
      if (result_valid !== 1'b0) begin
        n_fail++; $display("FAIL basic_ack got=%b exp=0", result_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int pre, mc;
    logic got;
    apply_reset();
    start_scan(4'b1000);
    do_meas(-1, '0, -1, pre, mc, got);
    n_run++;
    if (!got || mc != TMO_CYC) begin
      n_fail++; $display("FAIL timeout_len got v=%b cycles=%0d exp cycles=%0d", got, mc, TMO_CYC);
    end
    n_run++;
    if (result_ch !== 2'd3 || result_q !== '0 || result_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_result got ch=%0d q=%0d to=%b exp ch=3 q=0 to=1",
                         result_ch, result_q, result_timeout);
    end
    do_ack();
    do_meas(5, 10'd77, -1, pre, mc, got);
    n_run++;
    if (!got || pre != 1 + SETTLE || result_ch !== 2'd3 || result_q !== 10'd77 || result_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reselect got v=%b pre=%0d ch=%0d q=%0d to=%b exp ch=3 q=77 to=0",
                         got, pre, result_ch, result_q, result_timeout);
    end
    do_ack();
  endtask

  task automatic test_hold_stable();
    int pre, mc;
    logic got;
    apply_reset();
    q_serialized_in = '1;
    start_scan(4'b0010);
    do_meas(2, 10'd321, -1, pre, mc, got);
    for (int i = 0; i < 20; i++) begin
      meas_ready = 1'b1; meas_q = BW'($urandom);
      step();
      n_run++;
      if ({result_valid, result_ch, result_q, result_timeout, meas_start, meas_q_serialized}
          !== {1'b1, 2'd1, 10'd321, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d got v=%b ch=%0d q=%0d to=%b start=%b mux=%b exp v=1 ch=1 q=321 to=0 start=0 mux=0",
                 i, result_valid, result_ch, result_q, result_timeout, meas_start, meas_q_serialized);
      end
    end
    meas_ready = 1'b0;
    do_ack();
    n_run++;
    if (result_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_ack got=%b exp=0", result_valid);
    end
    do_meas(1, 10'd5, -1, pre, mc, got);
    n_run++;
    if (!got || pre != 1 + SETTLE || result_ch !== 2'd1 || result_q !== 10'd5) begin
      n_fail++; $display("FAIL hold_next got v=%b pre=%0d ch=%0d q=%0d exp pre=%0d ch=1 q=5",
                         got, pre, result_ch, result_q, 1 + SETTLE);
    end
    do_ack();
  endtask

  task automatic test_enable_drop();
    int pre, mc;
    logic got;
    apply_reset();
    start_scan(4'b0010);
    do_meas(6, 10'd200, 2, pre, mc, got);
    n_run++;
    if (!got || result_ch !== 2'd1 || result_q !== 10'd200 || result_timeout !== 1'b0) begin
      n_fail++; $display("FAIL endrop_result got v=%b ch=%0d q=%0d to=%b exp ch=1 q=200 to=0",
                         got, result_ch, result_q, result_timeout);
    end
    do_ack();
    for (int i = 0; i < 10; i++) begin
      n_run++;
      if (meas_start !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++; $display("FAIL endrop_idle cyc=%0d got start=%b valid=%b exp 0 0", i, meas_start, result_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int pre, mc, k;
    logic got;
    apply_reset();
    q_serialized_in = '1;
    start_scan(4'b1111);
    do_meas(0, 10'd11, -1, pre, mc, got);
    do_ack();
    k = 0;
    while (meas_start !== 1'b1 && k < 20) begin step(); k++; end
    step();
    #2 rst = 1'b1;
    #1;
    n_run++;
    if ({meas_start, result_valid, result_ch, result_q, result_timeout, meas_q_serialized} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got start=%b valid=%b ch=%0d q=%0d to=%b mux=%b exp all 0",
               meas_start, result_valid, result_ch, result_q, result_timeout, meas_q_serialized);
    end
    step();
    rst = 1'b0;
    do_meas(0, 10'd12, -1, pre, mc, got);
    n_run++;
    if (!got || result_ch !== 2'd0 || result_q !== 10'd12) begin
      n_fail++; $display("FAIL rstmid_first got v=%b ch=%0d q=%0d exp ch=0 q=12", got, result_ch, result_q);
    end
    do_ack();
  endtask

  task automatic test_mux();
    int k;
    logic [N_CH-1:0] pat;
    apply_reset();
    q_serialized_in = '1;
    start_scan(4'b0100);
    k = 0;
    while (meas_start !== 1'b1 && k < 10) begin
      n_run++;
      if (meas_q_serialized !== 1'b0) begin
        n_fail++; $display("FAIL mux_premeasure cyc=%0d got=%b exp=0", k, meas_q_serialized);
      end
      step(); k++;
    end
    for (int i = 0; i < 8; i++) begin
      pat = N_CH'($urandom);
      q_serialized_in = pat;
      #1;
      n_run++;
      if (meas_q_serialized !== pat[2]) begin
        n_fail++; $display("FAIL mux_route pat=%b got=%b exp=%b", pat, meas_q_serialized, pat[2]);
      end
      step();
    end
    meas_ready = 1'b1; meas_q = 10'd9;
    step();
    meas_ready = 1'b0;
    do_ack();
  endtask

  task automatic test_skip_zero();
    int pre, mc;
    logic got;
    apply_reset();
    start_scan(4'b0011);
    do_meas(1, 10'd0, -1, pre, mc, got);
`ifdef QSCHED_SKIP_ZERO_EN
    n_run++;
    if (got || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL skip_dropped got v=%b exp 0", result_valid);
    end
`else
    n_run++;
    if (!got || result_ch !== 2'd0 || result_q !== 10'd0 || result_timeout !== 1'b0) begin
      n_fail++; $display("FAIL skip_zero_reported got v=%b ch=%0d q=%0d to=%b exp ch=0 q=0 to=0",
                         got, result_ch, result_q, result_timeout);
    end
    do_ack();
`endif
    do_meas(1, 10'd60, -1, pre, mc, got);
    n_run++;
    if (!got || pre != 1 + SETTLE || result_ch !== 2'd1 || result_q !== 10'd60) begin
      n_fail++; $display("FAIL skip_next got v=%b pre=%0d ch=%0d q=%0d exp pre=%0d ch=1 q=60",
                         got, pre, result_ch, result_q, 1 + SETTLE);
    end
    do_ack();
  endtask

  task automatic test_random();
    int pre, mc, exp_cur, exp_ch, ra, exp_mc;
    logic got, tmo;
    logic [BW-1:0] qv;
    logic [N_CH-1:0] mask;
    apply_reset();
    mask = N_CH'($urandom_range(1, 15));
    start_scan(mask);
    exp_cur = N_CH - 1;
    for (int i = 0; i < 25; i++) begin
      exp_ch = ref_next(exp_cur, mask);
      exp_cur = exp_ch;
      tmo = ($urandom_range(0, 7) == 0);
      ra = tmo ? -1 : int'($urandom_range(0, 30));
      exp_mc = tmo ? TMO_CYC : ra + 1;
      qv = BW'($urandom_range(1, 1023));
      do_meas(ra, qv, -1, pre, mc, got);
      n_run++;
      if (!got || result_ch !== CH_W'(exp_ch) || result_q !== (tmo ? '0 : qv) || result_timeout !== tmo
          || mc != exp_mc) begin
        n_fail++;
        $display("FAIL rand_result it=%0d got v=%b ch=%0d q=%0d to=%b cyc=%0d exp ch=%0d q=%0d to=%b cyc=%0d",
                 i, got, result_ch, result_q, result_timeout, mc, exp_ch, tmo ? 0 : int'(qv), tmo, exp_mc);
      end
      mask = N_CH'($urandom_range(1, 15));
      ch_mask = mask;
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) step();
      do_ack();
      n_run++;
      if (result_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand_ack it=%0d got=%b exp=0", i, result_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ch_mask = '0; q_serialized_in = '0;
    meas_ready = 1'b0; meas_q = '0; result_ack = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_hold_stable();
    test_enable_drop();
    test_reset_mid();
    test_mux();
    test_skip_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/q_meas_scheduler.md
Name: q_meas_scheduler

Overview:
- Round-robin scheduler that shares one charge-measurement unit (pulse counter with watchdog and `start`/`ready` handshake) between N serialized charge-pulse channels.
- Per measurement it:
  - selects a channel and routes that channel's pulse line to the unit;
  - drives `start` low for a settle window, then high;
  - waits for `ready` or a timeout;
  - presents the tagged result to downstream logic with a valid/ack handshake.
- Sits between the analog front-end pulse outputs and the readout/serializer logic.

Parameters:
- N_CH, 4, number of pulse channels (2..16).
- BUS_WIDTH, 10, width of the measured-charge bus from the unit.
- CH_W, 2, channel index width; must satisfy 2**CH_W >= N_CH.
- SETTLE_CYC, 2, cycles `meas_start` is held low before each measurement (1..15).
- TIMEOUT_W, 8, timeout counter width; timeout fires at 2**TIMEOUT_W-1 cycles in MEASURE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  run scans while high.
- ch_mask  in  N_CH  channel enable bits; sampled only in SELECT.
- q_serialized_in  in  N_CH  pulse lines from the front-ends.
- meas_q_serialized  out  1  muxed pulse line to the measurement unit.
- meas_start  out  1  start/sync-clear to the measurement unit.
- meas_ready  in  1  unit measurement complete.
- meas_q  in  BUS_WIDTH  unit result; valid while `meas_ready`=1.
- result_valid  out  1  result available.
- result_ch  out  CH_W  channel index of the result.
- result_q  out  BUS_WIDTH  captured charge.
- result_timeout  out  1  result ended by timeout.
- result_ack  in  1  consumer accepts result.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; cur_ch=N_CH-1, so the first scan starts at channel 0.
  - meas_start=0, result_valid=0, result_ch=0, result_q=0, result_timeout=0.
  - All counters cleared.
  - Reset mid-measurement abandons it; no result is produced.
- meas_q_serialized = q_serialized_in[cur_ch] in state MEASURE only; otherwise 0 (combinational mux, no added latency).
- States:
  - IDLE: if enable=1 and ch_mask!=0 -> SELECT; else stay.
  - SELECT (1 cycle):
    - cur_ch <= lowest set ch_mask bit strictly above cur_ch, wrapping to the lowest set bit overall.
    - If ch_mask==0 -> IDLE; else -> SETTLE.
    - A single enabled channel is reselected every time.
  - SETTLE:
    - meas_start=0 for exactly SETTLE_CYC cycles (counter), then -> MEASURE.
  - MEASURE:
    - meas_start=1; the timeout counter increments every cycle from 0.
    - meas_ready=1: result_q<=meas_q, result_timeout<=0, result_ch<=cur_ch -> HOLD.
    - Else, counter reaching 2**TIMEOUT_W-1: result_q<=0, result_timeout<=1, result_ch<=cur_ch -> HOLD.
    - Ready and timeout in the same cycle: ready wins.
  - HOLD:
    - result_valid=1; meas_start=0 (holds the unit cleared).
    - result_ch, result_q and result_timeout are stable until acked.
    - On result_ack=1: result_valid deasserts the next cycle. Then -> SELECT if enable=1, else -> IDLE.
    - result_ack outside HOLD is ignored.
- Latency:
  - Measurement start to result_valid = 1 (SELECT) + SETTLE_CYC + MEASURE cycles + 1.
  - meas_ready seen in cycle k of MEASURE gives result_valid=1 on the next clock edge.
- Enable:
  - Dropping enable never aborts a measurement; the current result completes and is acked, then IDLE.
  - ch_mask changes mid-measurement take effect at the next SELECT.
- meas_ready is only acted on in MEASURE; it is ignored in every other state.

Optional Feature:
- Macro: QSCHED_SKIP_ZERO_EN.
- Defined:
  - A non-timeout result with meas_q==0 is dropped: no HOLD, result_valid stays 0, and the FSM goes directly to SELECT (or IDLE if enable=0).
  - Timeouts are still reported.
- Undefined: every completed measurement is reported.

Test Plan:
- Reset, then enable=1, ch_mask=4'b0101, unit returns 150 on ch0 and 90 on ch2, ack immediately -> results (ch0,150,to=0), (ch2,90,to=0), then ch0 again; meas_start low exactly 2 cycles before each MEASURE.
- ch_mask=4'b1000, meas_ready never asserted, TIMEOUT_W=8 -> result_valid 255 cycles after MEASURE entry+1 with ch=3, q=0, timeout=1; ch3 is reselected next.
- Withhold result_ack for 20 cycles -> result_valid, ch, q and timeout stable for all 20; meas_start=0; meas_q_serialized=0; then one cycle after ack, result_valid=0 and state SELECT.
- Drop enable mid-MEASURE on ch1 -> ch1 result still delivered; after ack the FSM is IDLE; meas_start=0.
- Assert rst mid-MEASURE -> all outputs 0 immediately; after release with enable=1 and mask=4'b1111 the first measured channel is 0.
- With QSCHED_SKIP_ZERO_EN defined, mask=4'b0011, ch0 returns 0 and ch1 returns 60 -> only (ch1,60) is reported; without the macro, (ch0,0) is also reported.
